three_input_demorgan_sweep: RTL and testbench
=============================================

THREE_INPUT_DEMORGAN_SWEEP -- requirements
Module: three_input_demorgan_sweep

Interface
REQ-001 Parameter: N, default 3, input-vector width; legal range 2..8.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  sweep request; sampled only in IDLE.
REQ-005 mode  input  1  0 = type-1 law ~(&x) vs |(~x); 1 = type-2 law ~(|x) vs &(~x).
REQ-006 fault_en  input  1  enables single-vector fault injection for the sweep.
REQ-007 fault_vec  input  N  vector at which injected fault inverts rhs.
REQ-008 busy  output  1  high in SWEEP and DRAIN states.
REQ-009 done  output  1  one-cycle pulse when sweep results are final.
REQ-010 pass  output  1  1 when last completed sweep had zero mismatches.
REQ-011 err_count  output  N+1  mismatch count of current/last sweep.
REQ-012 first_fail  output  N  first mismatching vector; valid only when err_count != 0.
REQ-013 vec  output  N  vector currently applied.
REQ-014 lhs, rhs  output  1 each  registered law sides for vector applied one cycle earlier.

Function
REQ-015 FSM states SHALL be IDLE, SWEEP, DRAIN1, DRAIN2, DONE.
REQ-016 IDLE: start=1 at edge E0 -> SWEEP; same edge latches mode, fault_en, fault_vec, sets vec=0, err_count=0, first_fail=0, pass=0.
REQ-017 start SHALL be ignored in every state except IDLE; latched mode/fault inputs SHALL NOT change mid-sweep.
REQ-018 SWEEP: vec increments by 1 per cycle; at edge where vec==2^N-1, vec holds and state -> DRAIN1.
REQ-019 Stage 1: lhs = ~(&vec) (mode 0) or ~(|vec) (mode 1); rhs = |(~vec) (mode 0) or &(~vec) (mode 1), registered, one cycle after vec.
REQ-020 If latched fault_en=1 and stage-1 vector equals latched fault_vec, rhs SHALL be inverted before registering.
REQ-021 Stage 2: one cycle after lhs/rhs, if lhs != rhs then err_count += 1; if err_count was 0, first_fail = that vector.
REQ-022 err_count width N+1 SHALL hold 2^N without overflow; no saturation logic needed.
REQ-023 DRAIN1 -> DRAIN2 -> DONE unconditionally, one cycle each, flushing the pipeline.
REQ-024 DONE: done=1 for exactly one cycle; pass = (err_count==0); next state IDLE.
REQ-025 done SHALL assert in the cycle beginning 2^N+2 edges after E0 (N=3: edge E10).
REQ-026 pass, err_count, first_fail SHALL hold their values in IDLE until the next accepted start.
REQ-027 start asserted in the DONE cycle SHALL be ignored; start in the following IDLE cycle SHALL be accepted.
REQ-028 busy = 1 in SWEEP, DRAIN1, DRAIN2; 0 in IDLE and DONE.

Reset
REQ-029 rst=1 SHALL immediately force IDLE and zero vec, lhs, rhs, busy, done, pass, err_count, first_fail and latched mode/fault registers.
REQ-030 rst asserted mid-sweep SHALL abort the sweep with no done pulse; after release, block waits for a new start.

Verification
REQ-031 N=3, mode=0, fault_en=0, start pulse -> vec 0..7, done at E10, err_count=0, pass=1.
REQ-032 N=3, mode=1, fault_en=1, fault_vec=3'b101 -> done at E10, err_count=1, first_fail=3'b101, pass=0.
REQ-033 N=3, start re-pulsed during SWEEP and on DONE cycle -> ignored; single done pulse, results unchanged.
REQ-034 N=3, rst asserted at vec=4 -> all outputs 0 asynchronously, no done; new start then completes normally with pass=1.
REQ-035 N=8, mode=0, fault_en=1, fault_vec=8'hFF -> done 258 cycles after start, err_count=1, first_fail=8'hFF.
REQ-036 Two back-to-back sweeps (fault then no fault) -> second sweep clears err_count/first_fail at start, ends pass=1.

Source files
------------

// File: rtl/three_input_demorgan_sweep.sv
// ============================================================================
// Module      : three_input_demorgan_sweep
// Description : Sweeps every N-bit vector through one of two De Morgan laws.
//               A two-stage pipeline compares the two sides of the law for
//               each vector. It counts mismatches and records the first
//               failing vector. A single-vector fault can be injected on the
//               right-hand side to exercise the checker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module three_input_demorgan_sweep #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         mode,
  input  logic         fault_en,
  input  logic [N-1:0] fault_vec,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [N:0]   err_count,
  output logic [N-1:0] first_fail,
  output logic [N-1:0] vec,
  output logic         lhs,
  output logic         rhs
);

  localparam logic [N-1:0] VEC_MAX = '1;
  localparam logic [N:0]   ERR_ONE = (N+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SWEEP  = 3'd1,
    S_DRAIN1 = 3'd2,
    S_DRAIN2 = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t       state_q, state_d;
  logic [N-1:0] vec_q, vec_d;
  logic         mode_q, mode_d;
  logic         fault_en_q, fault_en_d;
  logic [N-1:0] fault_vec_q, fault_vec_d;
  logic         lhs_q, lhs_d;
  logic         rhs_q, rhs_d;
  logic         s1_valid_q, s1_valid_d;
  logic [N-1:0] s1_vec_q, s1_vec_d;
  logic [N:0]   err_count_q, err_count_d;
  logic [N-1:0] first_fail_q, first_fail_d;
  logic         pass_q, pass_d;

  logic         w_lhs;
  logic         w_rhs;

  // Stage-1 law evaluation on the applied vector, with optional fault on rhs
  always_comb begin
    w_lhs = mode_q ? ~(|vec_q) : ~(&vec_q);
    w_rhs = mode_q ? &(~vec_q) : |(~vec_q);
    if (fault_en_q && (vec_q == fault_vec_q)) begin
      w_rhs = ~w_rhs;
    end
  end

  // Next-state, pipeline and result-accumulation logic
  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    mode_d       = mode_q;
    fault_en_d   = fault_en_q;
    fault_vec_d  = fault_vec_q;
    lhs_d        = lhs_q;
    rhs_d        = rhs_q;
    s1_vec_d     = s1_vec_q;
    err_count_d  = err_count_q;
    first_fail_d = first_fail_q;
    pass_d       = pass_q;

    // Stage 1 only captures vectors applied while sweeping, so the held
    // final vector during drain is never counted twice.
    s1_valid_d = (state_q == S_SWEEP);
    if (state_q == S_SWEEP) begin
      lhs_d    = w_lhs;
      rhs_d    = w_rhs;
      s1_vec_d = vec_q;
    end

    // Stage 2: tally mismatches and remember the first one
    if (s1_valid_q && (lhs_q != rhs_q)) begin
      err_count_d = err_count_q + ERR_ONE;
      if (err_count_q == '0) begin
        first_fail_d = s1_vec_q;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_SWEEP;
          mode_d       = mode;
          fault_en_d   = fault_en;
          fault_vec_d  = fault_vec;
          vec_d        = '0;
          err_count_d  = '0;
          first_fail_d = '0;
          pass_d       = 1'b0;
        end
      end
      S_SWEEP: begin
        if (vec_q == VEC_MAX) begin
          state_d = S_DRAIN1;
        end else begin
          vec_d = vec_q + 1'b1;
        end
      end
      S_DRAIN1: state_d = S_DRAIN2;
      S_DRAIN2: begin
        state_d = S_DONE;
        pass_d  = (err_count_d == '0);
      end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      vec_q        <= '0;
      mode_q       <= 1'b0;
      fault_en_q   <= 1'b0;
      fault_vec_q  <= '0;
      lhs_q        <= 1'b0;
      rhs_q        <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_vec_q     <= '0;
      err_count_q  <= '0;
      first_fail_q <= '0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      mode_q       <= mode_d;
      fault_en_q   <= fault_en_d;
      fault_vec_q  <= fault_vec_d;
      lhs_q        <= lhs_d;
      rhs_q        <= rhs_d;
      s1_valid_q   <= s1_valid_d;
      s1_vec_q     <= s1_vec_d;
      err_count_q  <= err_count_d;
      first_fail_q <= first_fail_d;
      pass_q       <= pass_d;
    end
  end

  // Output decode
  always_comb begin
    busy       = (state_q == S_SWEEP) || (state_q == S_DRAIN1) ||
                 (state_q == S_DRAIN2);
    done       = (state_q == S_DONE);
    pass       = pass_q;
    err_count  = err_count_q;
    first_fail = first_fail_q;
    vec        = vec_q;
    lhs        = lhs_q;
    rhs        = rhs_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_three_input_demorgan_sweep.sv
// ============================================================================
// Module      : tb_three_input_demorgan_sweep
// Description : Self-checking bench for three_input_demorgan_sweep (N=3 and
//               N=8 instances) against a behavioural model of the sweep.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_three_input_demorgan_sweep;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic       start3 = 1'b0, mode3 = 1'b0, fen3 = 1'b0;
  logic [2:0] fvec3 = '0;
  logic       busy3, done3, pass3, lhs3, rhs3;
  logic [3:0] err3;
  logic [2:0] ff3, vec3;

  logic       start8 = 1'b0, mode8 = 1'b0, fen8 = 1'b0;
  logic [7:0] fvec8 = '0;
  logic       busy8, done8, pass8, lhs8, rhs8;
  logic [8:0] err8;
  logic [7:0] ff8, vec8;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  three_input_demorgan_sweep #(.N(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .mode(mode3), .fault_en(fen3),
    .fault_vec(fvec3), .busy(busy3), .done(done3), .pass(pass3),
    .err_count(err3), .first_fail(ff3), .vec(vec3), .lhs(lhs3), .rhs(rhs3)
  );

  three_input_demorgan_sweep #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .mode(mode8), .fault_en(fen8),
    .fault_vec(fvec8), .busy(busy8), .done(done8), .pass(pass8),
    .err_count(err8), .first_fail(ff8), .vec(vec8), .lhs(lhs8), .rhs(rhs8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference law sides: "not all ones" / "all zeros" are the plain meanings
  // of the type-1 and type-2 laws; both sides agree unless the fault hits.
  function automatic bit ref_lhs(input bit m, input int x, input int n);
    return m ? (x == 0) : (x != (1 << n) - 1);
  endfunction

  function automatic bit ref_rhs(input bit m, input bit fe, input int fv, input int x, input int n);
    bit r;
    r = m ? (x == 0) : (x != (1 << n) - 1);
    if (fe && x == fv) r = !r;
    return r;
  endfunction

  function automatic void ref_sweep(input bit m, input bit fe, input int fv, input int n,
                                    output int err, output int ff);
    err = 0;
    ff  = 0;
    for (int x = 0; x < (1 << n); x++) begin
      if (ref_lhs(m, x, n) != ref_rhs(m, fe, fv, x, n)) begin
        if (err == 0) ff = x;
        err++;
      end
    end
  endfunction

  // One full N=3 sweep with per-cycle checks. With poke set, start is
  // re-asserted mid-sweep and in the DONE cycle, and the mode/fault inputs
  // are scrambled to confirm they were latched.
  task automatic sweep3(input bit m, input bit fe, input logic [2:0] fv, input bit poke);
    int exp_err, exp_ff;
    ref_sweep(m, fe, int'(fv), 3, exp_err, exp_ff);
    @(negedge clk);
    start3 = 1'b1; mode3 = m; fen3 = fe; fvec3 = fv;
    @(posedge clk); #1;
    chk("e0_vec", 32'(vec3), 32'd0);
    chk("e0_busy", 32'(busy3), 32'd1);
    chk("e0_err", 32'(err3), 32'd0);
    chk("e0_pass", 32'(pass3), 32'd0);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      start3 = poke && ((k >= 2 && k <= 5) || k == 11);
      if (poke) begin
        mode3 = 1'($urandom); fen3 = 1'($urandom); fvec3 = 3'($urandom);
      end
      @(posedge clk); #1;
      chk("vec", 32'(vec3), 32'((k < 7) ? k : 7));
      chk("busy", 32'(busy3), 32'(k <= 9));
      chk("done", 32'(done3), 32'(k == 10));
      if (k <= 8) begin
        chk("lhs", 32'(lhs3), 32'(ref_lhs(m, k - 1, 3)));
        chk("rhs", 32'(rhs3), 32'(ref_rhs(m, fe, int'(fv), k - 1, 3)));
      end
      if (k == 10) begin
        chk("err_count", 32'(err3), 32'(exp_err));
        chk("pass", 32'(pass3), 32'(exp_err == 0));
        if (exp_err != 0) chk("first_fail", 32'(ff3), 32'(exp_ff));
      end
    end
    @(negedge clk);
    start3 = 1'b0;
    @(posedge clk); #1;
    chk("idle_busy", 32'(busy3), 32'd0);
    chk("idle_err_hold", 32'(err3), 32'(exp_err));
    chk("idle_pass_hold", 32'(pass3), 32'(exp_err == 0));
  endtask

  initial begin
    int cnt;
    #1 rst = 1'b1;
    #2;
    chk("rst_vec", 32'(vec3), 32'd0);
    chk("rst_busy", 32'(busy3), 32'd0);
    chk("rst_done", 32'(done3), 32'd0);
    chk("rst_pass", 32'(pass3), 32'd0);
    chk("rst_err", 32'(err3), 32'd0);
    chk("rst_lhs", 32'(lhs3), 32'd0);
    chk("rst_vec8", 32'(vec8), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // Clean type-1 sweep, then type-2 with a fault at 3'b101
    sweep3(1'b0, 1'b0, 3'd0, 1'b0);
    sweep3(1'b1, 1'b1, 3'b101, 1'b0);
    // Ignored starts mid-sweep and in DONE
    sweep3(1'b1, 1'b1, 3'b010, 1'b1);

    // Asynchronous reset part-way through a sweep
    @(negedge clk);
    start3 = 1'b1; mode3 = 1'b0; fen3 = 1'b0;
    @(posedge clk); #1;
    @(negedge clk) start3 = 1'b0;
    repeat (4) @(posedge clk);
    #1 chk("pre_rst_vec", 32'(vec3), 32'd4);
    @(negedge clk) rst = 1'b1;
    #1;
    chk("arst_vec", 32'(vec3), 32'd0);
    chk("arst_busy", 32'(busy3), 32'd0);
    chk("arst_lhs", 32'(lhs3), 32'd0);
    chk("arst_rhs", 32'(rhs3), 32'd0);
    chk("arst_err", 32'(err3), 32'd0);
    chk("arst_ff", 32'(ff3), 32'd0);
    chk("arst_pass", 32'(pass3), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      chk("abort_done", 32'(done3), 32'd0);
      chk("abort_busy", 32'(busy3), 32'd0);
    end
    sweep3(1'b0, 1'b0, 3'd0, 1'b0);

    // Back-to-back fault then clean sweep
    sweep3(1'b0, 1'b1, 3'b000, 1'b0);
    sweep3(1'b1, 1'b0, 3'b000, 1'b0);

    // Randomized sweeps
    repeat (5) sweep3(1'($urandom), 1'($urandom), 3'($urandom_range(0, 7)), 1'($urandom));

    // N=8 sweep with a fault at the last vector
    @(negedge clk);
    start8 = 1'b1; mode8 = 1'b0; fen8 = 1'b1; fvec8 = 8'hFF;
    @(posedge clk); #1;
    chk("n8_busy", 32'(busy8), 32'd1);
    @(negedge clk) start8 = 1'b0;
    cnt = 0;
    while (!done8 && cnt < 400) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("n8_latency", 32'(cnt), 32'd258);
    chk("n8_err", 32'(err8), 32'd1);
    chk("n8_ff", 32'(ff8), 32'hFF);
    chk("n8_pass", 32'(pass8), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
